adc_serial_responder: RTL

Synchronous model of a two-channel 8-bit serial ADC (ADC0832-style) that answers the frames issued by the coordinate reader. It sits on the far side of one chip-select line: it decodes start and channel-select bits shifted in on `di` and returns the selected channel's sample MSB-first on `do`. It is used in simulation benches and as an on-FPGA ADC emulator for bring-up; one instance per chip select (cs0, cs1).

---
 rtl/adc_pkg.sv | 19 +
 rtl/adc_serial_responder_if.sv | 11 +
 rtl/adc_sync_edge.sv | 37 +++
 rtl/adc_serial_responder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared ADC frame definitions: FSM states, default width, command bit positions
package adc_pkg;

    localparam int ADC_DATA_W    = 8;
    localparam int ADC_START_POS = 0;
    localparam int ADC_SGL_POS   = 1;
    localparam int ADC_ODD_POS   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_CFG,
        ST_MUX,
        ST_DATA,
        ST_LSBR,
        ST_HOLD
    } adc_state_t;

endpackage

// File: rtl/adc_serial_responder_if.sv
// rtl/adc_serial_responder_if.sv - serial ADC pin bundle between reader (master) and responder (slave)
interface adc_serial_responder_if;
    logic sclk;
    logic cs_n;
    logic di;
    logic sdo;
    logic do_oe;

    modport master (output sclk, output cs_n, output di, input sdo, input do_oe);
    modport slave  (input sclk, input cs_n, input di, output sdo, output do_oe);
endinterface

// File: rtl/adc_sync_edge.sv
// rtl/adc_sync_edge.sv - N-stage synchronizer; one edge-detected input plus level-only inputs
module adc_sync_edge #(
    parameter int                   STAGES    = 2,
    parameter int                   LEVEL_W   = 2,
    parameter logic [LEVEL_W-1:0]   LEVEL_RST = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               edge_in,
    input  logic [LEVEL_W-1:0] level_in,
    output logic               rise,
    output logic               fall,
    output logic [LEVEL_W-1:0] level_sync
);

    logic [STAGES-1:0]  edge_q;
    logic               edge_dly;
    logic [LEVEL_W-1:0] lvl_q [STAGES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_q   <= '0;
            edge_dly <= 1'b0;
            for (int i = 0; i < STAGES; i++) lvl_q[i] <= LEVEL_RST;
        end else begin
            edge_q   <= {edge_q[STAGES-2:0], edge_in};
            edge_dly <= edge_q[STAGES-1];
            lvl_q[0] <= level_in;
            for (int i = 1; i < STAGES; i++) lvl_q[i] <= lvl_q[i-1];
        end
    end

    assign rise       = edge_q[STAGES-1] & ~edge_dly;
    assign fall       = ~edge_q[STAGES-1] & edge_dly;
    assign level_sync = lvl_q[STAGES-1];

endmodule

// File: rtl/adc_serial_responder.sv
// rtl/adc_serial_responder.sv - ADC0832-style two-channel serial ADC responder; ADC_LSB_REPEAT_EN adds LSB-first tail
module adc_serial_responder import adc_pkg::*; #(
    parameter int DATA_W      = ADC_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    adc_serial_responder_if.slave bus,
    input  logic [DATA_W-1:0]     ch0_data,
    input  logic [DATA_W-1:0]     ch1_data,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    adc_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shreg_q;
    logic              sdo_q, sdo_d, oe_q, oe_d, busy_q, busy_d, fd_q, fd_d;
    logic              sclk_rise, sclk_fall, cs_sync, di_sync, abort, last_data;

    // cs_n resets high so a freshly reset responder does not see a phantom select
    adc_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .LEVEL_W   (2),
        .LEVEL_RST (2'b01)
    ) u_sync (
        .clk        (clk),
        .rst        (rst),
        .edge_in    (bus.sclk),
        .level_in   ({bus.di, bus.cs_n}),
        .rise       (sclk_rise),
        .fall       (sclk_fall),
        .level_sync ({di_sync, cs_sync})
    );

    assign abort     = cs_sync && (state_q != ST_IDLE);
    assign last_data = (cnt_q == CNT_W'(DATA_W - 1));
`ifdef ADC_LSB_REPEAT_EN
    logic last_lsbr;
    assign last_lsbr = (cnt_q == CNT_W'(DATA_W - 2));
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (!cs_sync) state_d = ST_START;
                ST_START: if (sclk_rise && di_sync) state_d = ST_CFG;
                ST_CFG:   if (sclk_rise && cnt_q == CNT_W'(ADC_ODD_POS)) state_d = ST_MUX;
                ST_MUX:   if (sclk_fall) state_d = ST_DATA;
`ifdef ADC_LSB_REPEAT_EN
                ST_DATA:  if (sclk_fall && last_data) state_d = ST_LSBR;
                ST_LSBR:  if (sclk_fall && last_lsbr) state_d = ST_HOLD;
`else
                ST_DATA:  if (sclk_fall && last_data) state_d = ST_HOLD;
`endif
                ST_HOLD:  state_d = ST_HOLD;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        sdo_d  = sdo_q;
        oe_d   = oe_q;
        fd_d   = 1'b0;
        busy_d = (state_q != ST_IDLE);
        if (abort) begin
            sdo_d = 1'b0;
            oe_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sdo_d = 1'b0;
                    oe_d  = 1'b0;
                end
                ST_MUX: if (sclk_fall) begin
                    sdo_d = 1'b0;
                    oe_d  = 1'b1;
                end
                ST_DATA: if (sclk_fall) begin
                    sdo_d = shreg_q[DATA_W-1];
`ifndef ADC_LSB_REPEAT_EN
                    fd_d  = last_data;
`endif
                end
`ifdef ADC_LSB_REPEAT_EN
                ST_LSBR: if (sclk_fall) begin
                    sdo_d = shreg_q[1];
                    fd_d  = last_lsbr;
                end
`endif
                // the last bit stays on the pin until the master's next falling edge
                ST_HOLD: if (sclk_fall) begin
                    sdo_d = 1'b0;
                    oe_d  = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // DATA rotates left so the word is intact again for the LSB-first tail
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            shreg_q <= '0;
            sdo_q   <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            sdo_q  <= sdo_d;
            oe_q   <= oe_d;
            busy_q <= busy_d;
            fd_q   <= fd_d;
            if (abort) begin
                cnt_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE:  cnt_q <= CNT_W'(ADC_START_POS);
                    ST_START: if (sclk_rise && di_sync) cnt_q <= CNT_W'(ADC_SGL_POS);
                    ST_CFG: if (sclk_rise) begin
                        if (cnt_q == CNT_W'(ADC_ODD_POS)) begin
                            cnt_q   <= '0;
                            shreg_q <= di_sync ? ch1_data : ch0_data;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_DATA: if (sclk_fall) begin
                        shreg_q <= {shreg_q[DATA_W-2:0], shreg_q[DATA_W-1]};
                        cnt_q   <= last_data ? '0 : cnt_q + 1'b1;
                    end
`ifdef ADC_LSB_REPEAT_EN
                    ST_LSBR: if (sclk_fall) begin
                        shreg_q <= {shreg_q[0], shreg_q[DATA_W-1:1]};
                        cnt_q   <= cnt_q + 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign bus.sdo    = sdo_q;
    assign bus.do_oe  = oe_q;
    assign busy       = busy_q;
    assign frame_done = fd_q;

endmodule
